sub_array_stream_loader: RTL and testbench



---
 rtl/sub_array_pkg.sv | 18 +
 rtl/sub_array_index_gen.sv | 63 ++++++
 rtl/sub_array_stream_loader.sv | 122 ++++++++++++
 tb/tb_sub_array_stream_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_array_pkg.sv
// Shared types and sizing helpers for the sub-array stream loader/unloader family.
package sub_array_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_e;

  // Counter width for a range of n values; never below one bit so empty regions still elaborate.
  function automatic int cnt_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sub_array_index_gen.sv
// Region/column/sub-row walker producing (row, col) in sub-array-major, column-by-column order.
module sub_array_index_gen
  import sub_array_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int SUB_ROWS = 4,
  localparam int RW      = cnt_w(ROWS),
  localparam int CW      = cnt_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  localparam int LOW_ROWS = ROWS - SUB_ROWS;
  localparam int IW = (cnt_w(SUB_ROWS) > cnt_w(LOW_ROWS)) ? cnt_w(SUB_ROWS) : cnt_w(LOW_ROWS);
  localparam logic [IW-1:0] I_MAX0 = IW'(SUB_ROWS - 1);
  localparam logic [IW-1:0] I_MAX1 = (LOW_ROWS > 0) ? IW'(LOW_ROWS - 1) : {IW{1'b0}};
  localparam logic [CW-1:0] C_MAX  = CW'(COLS - 1);

  logic          region_q;
  logic [CW-1:0] col_q;
  logic [IW-1:0] i_q;
  logic          i_wrap_s;
  logic          region_end_s;

  assign i_wrap_s     = (i_q == (region_q ? I_MAX1 : I_MAX0));
  assign region_end_s = i_wrap_s && (col_q == C_MAX);
  // With an empty lower region the upper region's end is the frame's end.
  assign last_o       = region_end_s && (region_q || (LOW_ROWS == 0));
  assign row_o        = region_q ? (RW'(SUB_ROWS) + RW'(i_q)) : RW'(i_q);
  assign col_o        = col_q;

  // Counter advance: sub-row fastest, then column, then region.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q <= 1'b0;
      col_q    <= {CW{1'b0}};
      i_q      <= {IW{1'b0}};
    end else if (clear_i) begin
      region_q <= 1'b0;
      col_q    <= {CW{1'b0}};
      i_q      <= {IW{1'b0}};
    end else if (advance_i) begin
      if (region_end_s) begin
        region_q <= (LOW_ROWS == 0) ? 1'b0 : ~region_q;
        col_q    <= {CW{1'b0}};
        i_q      <= {IW{1'b0}};
      end else if (i_wrap_s) begin
        col_q <= col_q + CW'(1);
        i_q   <= {IW{1'b0}};
      end else begin
        i_q <= i_q + IW'(1);
      end
    end
  end

endmodule

// File: rtl/sub_array_stream_loader.sv
// Fills a ROWS x COLS array from an element stream and hands the frame over via valid/ready.
// Optional abort input enabled by defining SUB_ARRAY_LOADER_FLUSH_EN.
module sub_array_stream_loader
  import sub_array_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SUB_ROWS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out [ROWS-1:0][COLS-1:0],
  output logic                 busy
);

  localparam int RW = cnt_w(ROWS);
  localparam int CW = cnt_w(COLS);

  if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
    $error("sub_array_stream_loader: SUB_ROWS must lie in 1..ROWS");
  end

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic [BIT_WIDTH-1:0] out_q [ROWS-1:0][COLS-1:0];

  logic          flush_s;
  logic          beat_s;
  logic [RW-1:0] row_s;
  logic [CW-1:0] col_s;
  logic          last_s;

`ifdef SUB_ARRAY_LOADER_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // A beat coinciding with flush is dropped.
  assign beat_s = in_valid && in_ready_q && !flush_s;

  sub_array_index_gen #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SUB_ROWS (SUB_ROWS)
  ) u_index_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (flush_s),
    .advance_i (beat_s),
    .row_o     (row_s),
    .col_o     (col_s),
    .last_o    (last_s)
  );

  // Frame FSM with registered handshake outputs and the array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          out_q[r][c] <= {BIT_WIDTH{1'b0}};
        end
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (flush_s) begin
            busy_q <= 1'b0;
          end else if (beat_s) begin
            out_q[row_s][col_s] <= in_data;
            if (last_s) begin
              state_q     <= FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              busy_q <= 1'b1;
            end
          end else begin
            busy_q <= busy_q;
          end
        end
        FULL: begin
          if (flush_s || out_ready) begin
            state_q     <= LOAD;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule

// File: tb/tb_sub_array_stream_loader.sv
// Directed bench: three loader instances (SUB_ROWS 4, 8, 1) share one element stream.
module tb_sub_array_stream_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
  logic       flush;
`endif

  logic       in_ready_a, out_valid_a, busy_a;
  logic       in_ready_b, out_valid_b, busy_b;
  logic       in_ready_c, out_valid_c, busy_c;
  logic [7:0] out_a [7:0][7:0];
  logic [7:0] out_b [7:0][7:0];
  logic [7:0] out_c [7:0][7:0];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_array_stream_loader #(.BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .busy(busy_a)
  );

  sub_array_stream_loader #(.BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .busy(busy_b)
  );

  sub_array_stream_loader #(.BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out(out_c), .busy(busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one element and hold it until accepted; the task returns 1 time unit after the accepting edge.
  task automatic send(input int v);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v[7:0];
    while (in_ready_a !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    flush     = 1'b0;
`endif
    #12;
    chk("rst_in_ready",  in_ready_a,  32'd1);
    chk("rst_out_valid", out_valid_a, 32'd0);
    chk("rst_busy",      busy_a,      32'd0);
    chk("rst_out_a35",   out_a[3][5], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame, beat k carries k.
    for (int k = 0; k < 64; k++) begin
      send(k);
      if (k == 0) chk("s1_busy_first", busy_a, 32'd1);
      if (k == 62) chk("s1_not_valid_early", out_valid_a, 32'd0);
    end
    chk("s1_out_valid",  out_valid_a, 32'd1);
    chk("s1_in_ready",   in_ready_a,  32'd0);
    chk("s1_busy_done",  busy_a,      32'd0);
    chk("s1_b_valid",    out_valid_b, 32'd1);
    chk("s1_c_valid",    out_valid_c, 32'd1);
    chk("s1_a00", out_a[0][0], 32'd0);
    chk("s1_a30", out_a[3][0], 32'd3);
    chk("s1_a01", out_a[0][1], 32'd4);
    chk("s1_a37", out_a[3][7], 32'd31);
    chk("s1_a40", out_a[4][0], 32'd32);
    chk("s1_a51", out_a[5][1], 32'd37);
    chk("s1_a77", out_a[7][7], 32'd63);
    chk("s1_b70", out_b[7][0], 32'd7);
    chk("s1_b01", out_b[0][1], 32'd8);
    chk("s1_b35", out_b[3][5], 32'd43);
    chk("s1_b77", out_b[7][7], 32'd63);
    chk("s1_c07", out_c[0][7], 32'd7);
    chk("s1_c10", out_c[1][0], 32'd8);
    chk("s1_c70", out_c[7][0], 32'd14);
    chk("s1_c11", out_c[1][1], 32'd15);
    chk("s1_c77", out_c[7][7], 32'd63);
    @(posedge clk);
    #1;
    chk("s1_handover_valid", out_valid_a, 32'd0);
    chk("s1_handover_ready", in_ready_a,  32'd1);

    // Gapped frame, beat k carries 255-k, consumer stalls.
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) begin
      repeat ((k * 7) % 3) @(negedge clk);
      send(255 - k);
      if (k == 5) chk("s2_busy_mid", busy_a, 32'd1);
    end
    chk("s2_out_valid", out_valid_a, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      chk("s2_hold_in_ready",  in_ready_a,  32'd0);
      chk("s2_hold_out_valid", out_valid_a, 32'd1);
      chk("s2_hold_a00",       out_a[0][0], 32'd255);
      chk("s2_hold_a37",       out_a[3][7], 32'd224);
      chk("s2_hold_a77",       out_a[7][7], 32'd192);
    end
    chk("s2_busy_full", busy_a,      32'd0);
    chk("s2_a51",       out_a[5][1], 32'd218);
    chk("s2_b23",       out_b[2][3], 32'd229);
    chk("s2_c11",       out_c[1][1], 32'd240);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("s2_release_valid", out_valid_a, 32'd0);
    chk("s2_release_ready", in_ready_a,  32'd1);

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 21; k++) send(k);
    chk("s3_busy_before", busy_a, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s3_rst_busy",      busy_a,      32'd0);
    chk("s3_rst_in_ready",  in_ready_a,  32'd1);
    chk("s3_rst_out_valid", out_valid_a, 32'd0);
    chk("s3_rst_a40",       out_a[4][0], 32'd0);
    chk("s3_rst_c10",       out_c[1][0], 32'd0);
    chk("s3_rst_b23",       out_b[2][3], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 64; k++) send(k);
    chk("s3_out_valid", out_valid_a, 32'd1);
    chk("s3_a01",       out_a[0][1], 32'd4);
    chk("s3_a51",       out_a[5][1], 32'd37);
    chk("s3_a77",       out_a[7][7], 32'd63);
    chk("s3_b70",       out_b[7][0], 32'd7);
    chk("s3_c70",       out_c[7][0], 32'd14);
    @(posedge clk);
    #1;

`ifdef SUB_ARRAY_LOADER_FLUSH_EN
    // Flush together with beat 10 drops that beat and restarts the frame.
    for (int k = 0; k < 10; k++) send(k);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd10;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("s4_flush_busy",     busy_a,      32'd0);
    chk("s4_flush_in_ready", in_ready_a,  32'd1);
    chk("s4_flush_valid",    out_valid_a, 32'd0);
    for (int k = 0; k < 64; k++) begin
      send(k);
      if (k == 62) chk("s4_not_valid_early", out_valid_a, 32'd0);
    end
    chk("s4_out_valid", out_valid_a, 32'd1);
    chk("s4_a22",       out_a[2][2], 32'd10);
    chk("s4_a51",       out_a[5][1], 32'd37);
    chk("s4_a77",       out_a[7][7], 32'd63);
    @(posedge clk);
    #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
